// File: rtl/ub_ctrl_pkg.sv
// Shared widths, helper and read-FSM state encoding for the unified buffer controller.
package ub_ctrl_pkg;

   function automatic int clogb2(input int unsigned value);
      int unsigned v;
      int          n;
      v = value;
      n = 0;
      while (v > 0) begin
         n++;
         v = v >> 1;
      end
      return n;
   endfunction

   localparam int RAM_WIDTH = 128;
   localparam int RAM_DEPTH = 256;
   localparam int ADDR_W    = clogb2(RAM_DEPTH - 1);
   localparam int LEN_W     = 9;

   typedef enum logic [1:0] {
      UB_IDLE  = 2'd0,
      UB_BURST = 2'd1,
      UB_DRAIN = 2'd2
   } ub_state_t;

endpackage

// File: rtl/ub_ctrl_if.sv
// Host/result write ports, burst command, read stream and BRAM pins of the unified buffer.
interface ub_ctrl_if import ub_ctrl_pkg::*; ();
   logic                 host_wr_valid;
   logic                 host_wr_ready;
   logic [ADDR_W-1:0]    host_wr_addr;
   logic [RAM_WIDTH-1:0] host_wr_data;
   logic                 res_wr_valid;
   logic                 res_wr_ready;
   logic [ADDR_W-1:0]    res_wr_addr;
   logic [RAM_WIDTH-1:0] res_wr_data;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [ADDR_W-1:0]    cmd_addr;
   logic [LEN_W-1:0]     cmd_len;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [RAM_WIDTH-1:0] rd_data;
   logic                 rd_last;
   logic                 done;
   logic                 bram_wea;
   logic [ADDR_W-1:0]    bram_addra;
   logic [RAM_WIDTH-1:0] bram_dina;
   logic                 bram_enb;
   logic [ADDR_W-1:0]    bram_addrb;
   logic [RAM_WIDTH-1:0] bram_doutb;

   modport slave (
      input  host_wr_valid, host_wr_addr, host_wr_data,
      output host_wr_ready,
      input  res_wr_valid, res_wr_addr, res_wr_data,
      output res_wr_ready,
      input  cmd_valid, cmd_addr, cmd_len,
      output cmd_ready,
      output rd_valid, rd_data, rd_last, done,
      input  rd_ready,
      output bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb,
      input  bram_doutb
   );

   modport master (
      output host_wr_valid, host_wr_addr, host_wr_data,
      input  host_wr_ready,
      output res_wr_valid, res_wr_addr, res_wr_data,
      input  res_wr_ready,
      output cmd_valid, cmd_addr, cmd_len,
      input  cmd_ready,
      input  rd_valid, rd_data, rd_last, done,
      output rd_ready,
      input  bram_wea, bram_addra, bram_dina, bram_enb, bram_addrb,
      output bram_doutb
   );
endinterface

// File: rtl/ub_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer flips to the other side after any grant.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic req_host,
   input  logic req_res,
   output logic gnt_host,
   output logic gnt_res
);

   logic favour_res;

   always_comb begin
      gnt_host = req_host && (!req_res || !favour_res);
      gnt_res  = req_res  && (!req_host || favour_res);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         favour_res <= 1'b0;
      end else if (gnt_host) begin
         favour_res <= 1'b1;
      end else if (gnt_res) begin
         favour_res <= 1'b0;
      end
   end

endmodule

// File: rtl/ub_ctrl.sv
// Unified buffer controller: arbitrated write port plus burst-read sequencer feeding a valid/ready stream.
module ub_ctrl import ub_ctrl_pkg::*; (
   input  logic      clk,
   input  logic      reset,
   ub_ctrl_if.slave  bus
);

   logic              gnt_host;
   logic              gnt_res;
   ub_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  remaining;
   logic              issue;

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_host (bus.host_wr_valid),
      .req_res  (bus.res_wr_valid),
      .gnt_host (gnt_host),
      .gnt_res  (gnt_res)
   );

   assign bus.host_wr_ready = gnt_host;
   assign bus.res_wr_ready  = gnt_res;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.bram_wea   <= 1'b0;
         bus.bram_addra <= '0;
         bus.bram_dina  <= '0;
      end else if (gnt_host) begin
         bus.bram_wea   <= 1'b1;
         bus.bram_addra <= bus.host_wr_addr;
         bus.bram_dina  <= bus.host_wr_data;
      end else if (gnt_res) begin
         bus.bram_wea   <= 1'b1;
         bus.bram_addra <= bus.res_wr_addr;
         bus.bram_dina  <= bus.res_wr_data;
      end else begin
         bus.bram_wea   <= 1'b0;
      end
   end

   // A new read is only issued when the word on doutb is absent or leaving, so a stalled
   // BRAM output register doubles as the holding buffer.
   always_comb begin
      issue = (state == UB_BURST) && (remaining != '0) && (!bus.rd_valid || bus.rd_ready);
   end

   assign bus.bram_enb   = issue;
   assign bus.bram_addrb = ptr;
   assign bus.rd_data    = bus.bram_doutb;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= UB_IDLE;
         ptr           <= '0;
         remaining     <= '0;
         bus.rd_valid  <= 1'b0;
         bus.rd_last   <= 1'b0;
         bus.done      <= 1'b0;
         bus.cmd_ready <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         if (issue) begin
            bus.rd_valid <= 1'b1;
            bus.rd_last  <= (remaining == LEN_W'(1));
            ptr          <= ptr + ADDR_W'(1);
            remaining    <= remaining - LEN_W'(1);
         end else if (bus.rd_valid && bus.rd_ready) begin
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
         end
         case (state)
            UB_IDLE: begin
               if (bus.cmd_valid) begin
                  ptr       <= bus.cmd_addr;
                  remaining <= bus.cmd_len;
                  if (bus.cmd_len == '0) begin
                     bus.done <= 1'b1;
                  end else begin
                     state         <= UB_BURST;
                     bus.cmd_ready <= 1'b0;
                  end
               end
            end
            UB_BURST: begin
               if (issue && remaining == LEN_W'(1)) begin
                  state <= UB_DRAIN;
               end
            end
            UB_DRAIN: begin
               if (bus.rd_valid && bus.rd_ready && bus.rd_last) begin
                  bus.done      <= 1'b1;
                  bus.cmd_ready <= 1'b1;
                  state         <= UB_IDLE;
               end
            end
            default: begin
               state         <= UB_IDLE;
               bus.cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/ub_ctrl.md
Name: ub_ctrl

Overview:
- Controller for the 256-entry x 128-bit unified buffer BRAM (16 lanes x 8b, simple dual port, 1-cycle registered read).
- Arbitrates the single write port between the host load path and the systolic-array result writeback path, using 2-way round-robin.
- Sequences the read port as burst reads (start address, length) into a valid/ready stream that feeds the systolic array input skew logic.

Parameters:
- RAM_WIDTH, 128, word width (16 x 8b)
- RAM_DEPTH, 256, entries
- ADDR_W, 8, clogb2(RAM_DEPTH-1)
- LEN_W, 9, burst length width (1..256)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-high
- host_wr_valid  in  1  host write request
- host_wr_ready  out  1  host write granted this cycle
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  RAM_WIDTH  host write data
- res_wr_valid  in  1  result writeback request
- res_wr_ready  out  1  result write granted this cycle
- res_wr_addr  in  ADDR_W  result write address
- res_wr_data  in  RAM_WIDTH  result write data
- cmd_valid  in  1  burst read command valid
- cmd_ready  out  1  controller idle, command accepted
- cmd_addr  in  ADDR_W  burst start address
- cmd_len  in  LEN_W  burst length in words
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  RAM_WIDTH  read word (driven from bram_doutb)
- rd_last  out  1  marks the final word of the burst
- done  out  1  one-cycle pulse when a burst completes
- bram_wea  out  1  BRAM write enable
- bram_addra  out  ADDR_W  BRAM write address
- bram_dina  out  RAM_WIDTH  BRAM write data
- bram_enb  out  1  BRAM read enable
- bram_addrb  out  ADDR_W  BRAM read address
- bram_doutb  in  RAM_WIDTH  BRAM read data

Behaviour:
- Reset values (async): bram_wea=0, bram_addra=0, bram_dina=0, rd_valid=0, rd_last=0, done=0, state=IDLE, rr pointer=host, cmd_ready=1.
- Write arbitration:
  - *_wr_ready is combinational grant: a requester is granted when valid and either it is the only requester or the rr pointer favours it.
  - After any grant, the pointer moves to the other requester.
  - The granted address and data are registered onto bram_wea/addra/dina. The BRAM write lands at clock edge t+1 after the handshake at t.
  - With no grant, bram_wea=0 and addr/data hold their previous values.
  - Write arbitration runs independently of the read FSM.
- Read FSM states: IDLE, BURST, DRAIN.
  - IDLE: cmd_ready=1. On cmd_valid, latch addr into ptr and len into remaining.
    - cmd_len=0: go to IDLE and pulse done next cycle. No read is issued.
    - cmd_len>0: go to BURST.
  - BURST: issue condition = remaining>0 && (!rd_valid || rd_ready).
    - On issue: bram_enb=1, bram_addrb=ptr (combinational from ptr), ptr<=ptr+1 (mod 256, wraps 255->0), remaining<=remaining-1.
    - rd_valid<=1 on the cycle after an issue. rd_last<=1 when the issued word was the last (remaining==1).
    - When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until the last word is consumed (rd_valid && rd_ready && rd_last). Then done=1 for one cycle and return to IDLE.
  - Stall behaviour: a word is consumed when rd_valid && rd_ready. If consumed with no new issue, rd_valid<=0.
    - When stalled, bram_enb=0, so the BRAM holds doutb.
    - rd_data is bram_doutb directly. No skid buffer is needed.
    - rd_data stays stable while rd_valid && !rd_ready.
  - Throughput: 1 word/cycle with rd_ready held high. First rd_valid appears 2 cycles after cmd acceptance (accept edge, then issue edge).
- Read/write collision: a same-address BRAM write and read on the same edge return the OLD data (read-first). The controller does not forward or interlock; the producer ordering owns this.
- Reset mid-burst: the burst is aborted, rd_valid drops immediately, and no done pulse is produced.

Decomposition:
- sa_share.v supplies RAM_WIDTH, RAM_DEPTH, clogb2, plus the new FSM state encodings UB_IDLE/UB_BURST/UB_DRAIN.
- One sub-module: rr_arb2, a 2-input round-robin arbiter with registered pointer, reset to favour host.

Test Plan:
- Host writes addr 0x05=A, res idle -> host_wr_ready=1 same cycle; bram_wea=1, addra=0x05, dina=A next cycle; burst (0x05, 1) returns A with rd_last=1, then done.
- Both requesters valid for 4 cycles (host addr 0x10.., res addr 0x20..) -> grants alternate host,res,host,res; each writes 2 words; readback matches.
- Burst (0xFE, 4) with rd_ready=1 -> words from 0xFE,0xFF,0x00,0x01 on consecutive cycles; rd_last only on the 4th; done 1 cycle after.
- Burst (0x00, 8) with rd_ready toggling 1,0,0,1... -> no word lost or duplicated; rd_data stable while stalled; bram_enb=0 during stall.
- cmd_len=0 -> no bram_enb, no rd_valid, done pulse once; cmd_ready returns to 1.
- Assert reset during BURST after 3 of 8 words -> rd_valid=0 immediately, state IDLE, no done; a new burst (0x00, 2) then works normally.
